// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo: queues toggle-flagged PS/2 key events from the ARM-side bus
// and replays them as single-cycle key_ready strobes spaced GAP+2 cycles
// apart, so the keyboard matrix scanner never misses a make or break.
module ps2_key_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int GAP        = 1000
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [10:0]           ps2_key,
  input  logic                  flush,
  output logic                  key_ready,
  output logic                  key_pressed,
  output logic [9:0]            key_code,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Gap counter only needs to hold GAP; keep at least one bit for GAP of 0 or 1.
  localparam int CNT_W = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]    GAP_LOAD   = CNT_W'(GAP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_old_tog;
  logic [9:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_overflow;
  logic [CNT_W-1:0]      r_gap_cnt;
  logic                  r_key_pressed;
  logic [9:0]            r_key_code;

  logic                  w_new_evt;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;

  // A toggle change is an event, except in reset/flush cycles where it is discarded.
  assign w_new_evt = (ps2_key[10] != r_old_tog) && !reset && !flush;
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == FULL_LEVEL);
  // Pop is suppressed during flush so the output registers keep their values.
  assign w_pop     = (r_state == S_IDLE) && !w_empty && !reset && !flush;
  // A pop on the same edge frees a slot, so a push into a full queue still lands.
  assign w_push    = w_new_evt && (!w_full || w_pop);
  assign w_drop    = w_new_evt && w_full && !w_pop;

  // Track the toggle level every cycle (reset and flush included) so a stale level never fires.
  always_ff @(posedge clk_sys) begin
    r_old_tog <= ps2_key[10];
  end

  // Event storage: {pressed, extended, scan code} written at the write pointer.
  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= ps2_key[9:0];
    end
  end

  // Pointers, occupancy counter and sticky overflow flag.
  always_ff @(posedge clk_sys) begin
    if (reset || flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Registered read of the queue head into the held output registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_key_pressed <= 1'b0;
      r_key_code    <= '0;
    end else if (w_pop) begin
      r_key_pressed <= r_mem[r_rd_ptr][9];
      r_key_code    <= {1'b0, r_mem[r_rd_ptr][8:0]};
    end
  end

  // Output FSM state register.
  always_ff @(posedge clk_sys) begin
    if (reset || flush) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Gap counter: loaded while the strobe is high, counts down through WAIT.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_gap_cnt <= '0;
    end else if (r_state == S_PULSE) begin
      r_gap_cnt <= GAP_LOAD;
    end else if (r_state == S_WAIT) begin
      r_gap_cnt <= r_gap_cnt - 1'b1;
    end
  end

  // Next-state logic: pop -> one strobe cycle -> GAP wait cycles -> back to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_next = S_PULSE;
        end
      end
      S_PULSE: begin
        if (GAP == 0) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_gap_cnt <= CNT_W'(1)) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs: strobe is decoded from the state, data comes from the held registers.
  always_comb begin
    key_ready   = (r_state == S_PULSE);
    key_pressed = r_key_pressed;
    key_code    = r_key_code;
    fifo_level  = r_level;
    overflow    = r_overflow;
  end

endmodule
